alu_seq: RTL
============

Name: alu_seq

Overview:
Parametrised, handshaked successor to the CPU's combinational ALU with a compare flag register. Adds valid/ready handshakes, signed and unsigned compares, shifts, a full status-flag set, and iterative multi-cycle multiply and divide. Sits between the CPU decode/issue stage and the register-file writeback. The CPU stalls on in_ready and out_valid instead of assuming single-cycle results.

Parameters:
DATA_WIDTH, 16, operand and result width; must be at least 4.
OPCODE_WIDTH, 4, opcode field width; must be at least 4.
SHAMT_WIDTH, $clog2(DATA_WIDTH), number of low bits of op_b used as the shift amount (derived; do not override).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous reset, active-low (asserted when 0).
in_valid  in  1  operation request.
in_ready  out  1  block can accept a request.
opcode  in  OPCODE_WIDTH  operation select.
op_a  in  DATA_WIDTH  operand A.
op_b  in  DATA_WIDTH  operand B.
out_valid  out  1  result and flags valid.
out_ready  in  1  consumer accepts the result.
result  out  DATA_WIDTH  registered result.
flags  out  8  registered flags: [0] equal, [1] less, [2] greater, [3] zero, [4] carry, [5] overflow, [6] div0, [7] illegal.

Behaviour:
- Reset (rst=0, asynchronous): state goes to IDLE; in_ready=1, out_valid=0, result=0, flags=0. Any in-flight operation is discarded, with no partial output.
- Handshake:
  - A request is accepted on a clk edge where in_valid && in_ready. Operands and opcode are captured at that edge.
  - in_ready=1 only in IDLE.
  - A result transfers on a clk edge where out_valid && out_ready.
  - While out_valid=1 && out_ready=0, result and flags hold stable.
- State machine:
  - IDLE → DONE on accept of a single-cycle op.
  - IDLE → BUSY on accept of MUL, DIVU or REMU with op_b≠0.
  - IDLE → DONE on accept of DIVU or REMU with op_b=0 (no iteration).
  - BUSY → DONE when the iteration counter reaches DATA_WIDTH−1.
  - DONE → IDLE on transfer. No accept is possible in the same cycle as the transfer.
- Latency (accept edge N):
  - Single-cycle ops: out_valid=1 after edge N+1.
  - MUL, DIVU, REMU: out_valid=1 after edge N+1+DATA_WIDTH.
- Opcodes:
  - 0 ADD
  - 1 SUB (a−b)
  - 2 MUL (iterative shift-add; result = low half of the product)
  - 3 AND
  - 4 OR
  - 5 XOR
  - 6 NOT a
  - 7 NEG (two's complement of a)
  - 8 CMP (unsigned)
  - 9 CMPS (signed)
  - A SHL
  - B SHR (logical)
  - C SRA
  - D DIVU (restoring divide; quotient)
  - E REMU (remainder)
  - F PASS b
  - Codes ≥16 (OPCODE_WIDTH>4): result=0 and illegal=1.
- Flag update rules (on the edge that enters DONE):
  - equal/less/greater: updated only by CMP/CMPS, with exactly one of the three set; otherwise retained. result=0 for compares.
  - zero: set when result==0, for every op.
  - carry: ADD carry-out; SUB/CMP borrow (a<b unsigned); otherwise 0.
  - overflow:
    - ADD/SUB: signed overflow.
    - MUL: set when the high half of the 2×DATA_WIDTH product is non-zero.
    - Otherwise 0.
  - div0 (DIVU/REMU only):
    - set when op_b=0; then quotient=all-ones and remainder=op_a.
    - cleared by any other op.
  - illegal: set only for undefined opcodes.
- Shifts: shift amount = op_b[SHAMT_WIDTH-1:0]; upper bits of op_b are ignored. A shift of 0 returns op_a.
- Arithmetic is modulo 2^DATA_WIDTH. The MUL product register is 2×DATA_WIDTH wide.
- in_valid while busy is not accepted. Operand changes have no effect after capture.

Decomposition:
- Package alu_seq_pkg:
  - alu_op_e enum (4-bit opcodes above).
  - State enum {IDLE, BUSY, DONE}.
  - Flag bit index localparams FLG_EQ..FLG_ILL.
- One sub-module, alu_iter_muldiv:
  - Holds the multi-cycle engine: counter, partial product/remainder and quotient registers, start/done pulses.
  - Mode input selects MUL or DIV.
- alu_seq holds the handshake FSM, the combinational single-cycle datapath and the output registers.

Test Plan:
1. ADD a=0xFFFF, b=0x0001 (DATA_WIDTH=16) → result=0x0000, zero=1, carry=1, overflow=0; out_valid exactly 1 cycle after accept.
2. MUL a=0x0123, b=0x0045 → result=0x4E6F, overflow=0, out_valid 17 cycles after accept. MUL a=0x1000, b=0x0010 → result=0x0000, overflow=1, zero=1.
3. DIVU 100/7 → 0x000E; REMU 100/7 → 0x0002 with 17-cycle latency. DIVU 0x1234/0 → result=0xFFFF, div0=1, 1-cycle latency.
4. CMP a=0xFFFF, b=0x0001 → greater=1. CMPS with the same operands → less=1. A following ADD leaves equal/less/greater unchanged.
5. Backpressure: complete SHL a=0x0001, b=0x00F3 → result=0x0008. Hold out_ready=0 for 3 cycles → result and flags stable, in_ready=0. Pulse in_valid during the hold → request not accepted.
6. Reset mid-MUL: drop rst to 0 at iteration 5 → out_valid=0, flags=0 immediately. After release, a fresh ADD completes normally. Undefined opcode 0x10 with OPCODE_WIDTH=5 → illegal=1, result=0.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared opcode, state and flag-index definitions for the sequential ALU.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_MUL  = 4'h2,
        OP_AND  = 4'h3,
        OP_OR   = 4'h4,
        OP_XOR  = 4'h5,
        OP_NOT  = 4'h6,
        OP_NEG  = 4'h7,
        OP_CMP  = 4'h8,
        OP_CMPS = 4'h9,
        OP_SHL  = 4'hA,
        OP_SHR  = 4'hB,
        OP_SRA  = 4'hC,
        OP_DIVU = 4'hD,
        OP_REMU = 4'hE,
        OP_PASS = 4'hF
    } alu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int unsigned FLAG_WIDTH = 8;
    localparam int unsigned FLG_EQ     = 0;
    localparam int unsigned FLG_LT     = 1;
    localparam int unsigned FLG_GT     = 2;
    localparam int unsigned FLG_ZERO   = 3;
    localparam int unsigned FLG_CARRY  = 4;
    localparam int unsigned FLG_OVF    = 5;
    localparam int unsigned FLG_DIV0   = 6;
    localparam int unsigned FLG_ILL    = 7;

    function automatic logic is_div_op(alu_op_e op);
        return (op == OP_DIVU) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Iterative engine: shift-add multiply or restoring divide, one bit per cycle.
// o_hi/o_lo hold {product high, product low} for MUL and {remainder, quotient} for DIV.
module alu_iter_muldiv #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_mul,
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [DATA_WIDTH-1:0] i_b,
    output logic                  o_last_c,
    output logic [DATA_WIDTH-1:0] o_hi,
    output logic [DATA_WIDTH-1:0] o_lo
);

    localparam int unsigned W     = DATA_WIDTH;
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;
    logic             r_mul;
    logic [W-1:0]     r_opnd;
    logic [W-1:0]     r_hi;
    logic [W-1:0]     r_lo;
    logic [W:0]       w_add;
    logic [W:0]       w_trial;

    assign w_add    = {1'b0, r_hi} + {1'b0, r_opnd};
    assign w_trial  = {r_hi, r_lo[W-1]} - {1'b0, r_opnd};
    assign o_last_c = r_busy && (r_cnt == CNT_W'(DATA_WIDTH - 1));
    assign o_hi     = r_hi;
    assign o_lo     = r_lo;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_mul  <= 1'b0;
            r_opnd <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else if (i_start) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_mul  <= i_mul;
            r_hi   <= '0;
            r_lo   <= i_mul ? i_b : i_a;
            r_opnd <= i_mul ? i_a : i_b;
        end else if (r_busy) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (o_last_c) begin
                r_busy <= 1'b0;
            end
            if (r_mul) begin
                // Add multiplicand when the multiplier LSB is set, then shift the product right.
                if (r_lo[0]) begin
                    r_hi <= w_add[W:1];
                    r_lo <= {w_add[0], r_lo[W-1:1]};
                end else begin
                    r_hi <= {1'b0, r_hi[W-1:1]};
                    r_lo <= {r_hi[0], r_lo[W-1:1]};
                end
            end else begin
                // Trial subtract; keep it only when it does not borrow.
                if (!w_trial[W]) begin
                    r_hi <= w_trial[W-1:0];
                end else begin
                    r_hi <= {r_hi[W-2:0], r_lo[W-1]};
                end
                r_lo <= {r_lo[W-2:0], ~w_trial[W]};
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU: captures a request, computes single-cycle ops directly or
// via the iterative mul/div engine, and holds result/flags until consumed.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned OPCODE_WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic [DATA_WIDTH-1:0]   op_a,
    input  logic [DATA_WIDTH-1:0]   op_b,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   result,
    output logic [FLAG_WIDTH-1:0]   flags
);

    localparam int unsigned W           = DATA_WIDTH;
    localparam int unsigned SHAMT_WIDTH = $clog2(DATA_WIDTH);

    state_e                r_state;
    state_e                w_state_next;
    alu_op_e               r_op;
    logic                  r_ill;
    logic [W-1:0]          r_a;
    logic [W-1:0]          r_b;

    alu_op_e               w_in_op;
    logic                  w_in_ill;
    logic                  w_in_iter;
    logic                  w_accept;
    logic                  w_start;
    logic                  w_load;
    logic                  w_xfer;

    logic                  w_eng_last;
    logic [W-1:0]          w_eng_hi;
    logic [W-1:0]          w_eng_lo;

    logic [W:0]            w_sum;
    logic [W:0]            w_diff;
    logic [SHAMT_WIDTH-1:0] w_shamt;
    logic [W-1:0]          w_res;
    logic                  w_carry;
    logic                  w_ovf;
    logic                  w_div0;
    logic                  w_cmp_upd;
    logic                  w_eq;
    logic                  w_lt;
    logic                  w_gt;
    logic [FLAG_WIDTH-1:0] w_flags;

    assign w_in_op   = alu_op_e'(opcode[3:0]);
    assign w_in_ill  = (OPCODE_WIDTH > 4) && ((opcode >> 4) != '0);
    assign w_in_iter = !w_in_ill &&
                       ((w_in_op == OP_MUL) || (is_div_op(w_in_op) && (op_b != '0)));

    // Next-state and handshake decode
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_start      = 1'b0;
        w_load       = 1'b0;
        w_xfer       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_start      = w_in_iter;
                    w_state_next = w_in_iter ? ST_BUSY : ST_DONE;
                end
            end
            ST_BUSY: begin
                if (w_eng_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!out_valid) begin
                    w_load = 1'b1;
                end else if (out_ready) begin
                    w_xfer       = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            in_ready <= 1'b1;
        end else begin
            r_state  <= w_state_next;
            in_ready <= (w_state_next == ST_IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op  <= OP_ADD;
            r_ill <= 1'b0;
            r_a   <= '0;
            r_b   <= '0;
        end else if (w_accept) begin
            r_op  <= w_in_op;
            r_ill <= w_in_ill;
            r_a   <= op_a;
            r_b   <= op_b;
        end
    end

    alu_iter_muldiv #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_muldiv (
        .clk      (clk),
        .rst      (rst),
        .i_start  (w_start),
        .i_mul    (w_in_op == OP_MUL),
        .i_a      (op_a),
        .i_b      (op_b),
        .o_last_c (w_eng_last),
        .o_hi     (w_eng_hi),
        .o_lo     (w_eng_lo)
    );

    assign w_sum   = {1'b0, r_a} + {1'b0, r_b};
    assign w_diff  = {1'b0, r_a} - {1'b0, r_b};
    assign w_shamt = r_b[SHAMT_WIDTH-1:0];

    // Result and flag datapath from the captured request
    always_comb begin
        w_res     = '0;
        w_carry   = 1'b0;
        w_ovf     = 1'b0;
        w_div0    = 1'b0;
        w_cmp_upd = 1'b0;
        w_eq      = 1'b0;
        w_lt      = 1'b0;
        w_gt      = 1'b0;
        if (!r_ill) begin
            case (r_op)
                OP_ADD: begin
                    w_res   = w_sum[W-1:0];
                    w_carry = w_sum[W];
                    w_ovf   = (r_a[W-1] == r_b[W-1]) && (w_sum[W-1] != r_a[W-1]);
                end
                OP_SUB: begin
                    w_res   = w_diff[W-1:0];
                    w_carry = w_diff[W];
                    w_ovf   = (r_a[W-1] != r_b[W-1]) && (w_diff[W-1] != r_a[W-1]);
                end
                OP_MUL: begin
                    w_res = w_eng_lo;
                    w_ovf = (w_eng_hi != '0);
                end
                OP_AND:  w_res = r_a & r_b;
                OP_OR:   w_res = r_a | r_b;
                OP_XOR:  w_res = r_a ^ r_b;
                OP_NOT:  w_res = ~r_a;
                OP_NEG:  w_res = W'(0) - r_a;
                OP_CMP: begin
                    w_cmp_upd = 1'b1;
                    w_eq      = (r_a == r_b);
                    w_lt      = (r_a < r_b);
                    w_gt      = (r_a > r_b);
                    w_carry   = w_diff[W];
                end
                OP_CMPS: begin
                    w_cmp_upd = 1'b1;
                    w_eq      = (r_a == r_b);
                    w_lt      = ($signed(r_a) < $signed(r_b));
                    w_gt      = ($signed(r_a) > $signed(r_b));
                end
                OP_SHL:  w_res = r_a << w_shamt;
                OP_SHR:  w_res = r_a >> w_shamt;
                OP_SRA:  w_res = $unsigned($signed(r_a) >>> w_shamt);
                OP_DIVU: begin
                    w_div0 = (r_b == '0);
                    w_res  = w_div0 ? '1 : w_eng_lo;
                end
                OP_REMU: begin
                    w_div0 = (r_b == '0);
                    w_res  = w_div0 ? r_a : w_eng_hi;
                end
                OP_PASS: w_res = r_b;
                default: w_res = '0;
            endcase
        end
        w_flags            = '0;
        w_flags[FLG_EQ]    = w_cmp_upd ? w_eq : flags[FLG_EQ];
        w_flags[FLG_LT]    = w_cmp_upd ? w_lt : flags[FLG_LT];
        w_flags[FLG_GT]    = w_cmp_upd ? w_gt : flags[FLG_GT];
        w_flags[FLG_ZERO]  = (w_res == '0);
        w_flags[FLG_CARRY] = w_carry;
        w_flags[FLG_OVF]   = w_ovf;
        w_flags[FLG_DIV0]  = w_div0;
        w_flags[FLG_ILL]   = r_ill;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            result    <= '0;
            flags     <= '0;
        end else if (w_load) begin
            out_valid <= 1'b1;
            result    <= w_res;
            flags     <= w_flags;
        end else if (w_xfer) begin
            out_valid <= 1'b0;
        end
    end

endmodule
